code_loader: RTL and testbench
==============================

# code_loader

Program loader for the instruction code RAM. It accepts instruction words over a valid/ready stream, writes them into consecutive code RAM entries starting at address 0, and commits the program length (`code_size`) once the last word arrives. The code RAM returns nop for any pc at or above `code_size`. `code_size` is therefore held at 0 for the whole load, so the fetch side executes nops until the new program is complete.

## Interface
- `CODESIZE`, default 8: code RAM depth, i.e. the maximum number of instructions in one program.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a new load.
- `in_valid`  in  1  `in_ins` and `in_last` are valid this cycle.
- `in_ready`  out  1  loader can accept a word.
- `in_ins`  in  `INSWIDTH`  instruction word.
- `in_last`  in  1  marks the final word of the program.
- `wr_en`  out  1  code RAM write strobe.
- `wr_addr`  out  `PCWIDTH`  code RAM write address.
- `wr_data`  out  `INSWIDTH`  code RAM write data.
- `code_size`  out  4  committed program length, 0..CODESIZE.
- `load_done`  out  1  high while in DONE.
- `err`  out  1  overflow flag. Present only when `CODE_LOADER_OVERFLOW_ERR_EN` is defined.

## Operation
- A word is accepted when `in_valid && in_ready`.
- Internal counter `cnt` (4 bits) holds the number of words written so far.
- States and transitions:
  - IDLE: `in_ready`=0. On `start`: `cnt`<=0, `code_size`<=0, go to LOAD.
  - LOAD: `in_ready`=1. `start` is ignored.
    - Accept with `cnt`<CODESIZE: write to address `cnt`, then `cnt`++.
    - If the accepted word has `in_last`: `code_size`<=`cnt`+1, go to DONE.
  - DONE: `in_ready`=0, `load_done`=1, `code_size` held. On `start`: clear `code_size` and `cnt`, go to LOAD.
  - ERR (macro only): `in_ready`=0, `err`=1, `code_size`=0. On `start`: clear and go to LOAD. `rst` also clears it.
- Overflow: a word accepted with `cnt`==CODESIZE. Handling is defined under Configuration.
- Words are written strictly in order. There are no gaps and no rewrites within one load.
- `rst` at any time, including mid-load:
  - all outputs go to 0, state goes to IDLE.
  - RAM contents are untouched but unreachable, because `code_size`=0.

## Timing
- Reset value of every output is 0.
- Write outputs are registered. `wr_en`, `wr_addr` and `wr_data` appear the cycle after the accept, and `wr_en` is high for exactly one cycle per accepted word.
- `code_size` and `load_done` update the cycle after the `in_last` accept. This is the same cycle as the final `wr_en`, so the RAM write and the size commit land together.
- `in_ready` rises the cycle after `start` and drops the cycle after the `in_last` accept. It is combinational from state only and never depends on `in_valid`.
- Throughput is one word per cycle with back-to-back `in_valid`.
- `start` and an accept in the same cycle: in LOAD, `start` is ignored and the accept proceeds. In IDLE or DONE no accept is possible, because `in_ready`=0.

## Configuration
- `CODE_LOADER_OVERFLOW_ERR_EN` defined:
  - an overflow word moves the state to ERR and sets `err`=1.
  - no write is issued, `code_size` stays 0, and the program is discarded.
- `CODE_LOADER_OVERFLOW_ERR_EN` undefined:
  - there is no `err` port and no ERR state.
  - overflow words are dropped silently.
  - an overflow word carrying `in_last` commits `code_size`=CODESIZE and moves to DONE.

## Structure
- The width macros `PCWIDTH` and `INSWIDTH` come from the shared `def.v`.
- Add the state encodings (`LDR_IDLE`, `LDR_LOAD`, `LDR_DONE`, `LDR_ERR`) to `def.v`.
- Single module, no sub-modules.
- Pairs with the code RAM through `wr_*` and `code_size`.

## Test plan
- Reset, then `start`, then 3 words (0x11, 0x22, 0x33 with last) -> writes at addr 0/1/2, `code_size`=3, `load_done`=1 the cycle after the last accept.
- `in_valid` toggling 1,0,1,0 during LOAD -> no write on idle cycles; addresses stay consecutive.
- 8 words with last on the 8th -> `code_size`=8, no overflow, `err`=0.
- 9th word (macro on) -> `err`=1, `code_size`=0, `in_ready`=0; `start` then 2 words -> `code_size`=2. With the macro off, the 9th word carrying last -> no 9th write, `code_size`=8.
- `rst` after 2 of 4 words -> next cycle all outputs 0 and state IDLE; `start` then reload from addr 0.
- In DONE with `code_size`=3, `start` -> `code_size`=0 the next cycle, `in_ready`=1.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared widths and loader state encodings for the code RAM program loader.
package code_loader_pkg;

    localparam int PCWIDTH  = 3;
    localparam int INSWIDTH = 16;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2,
        LDR_ERR  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/code_loader.sv
// Streams instruction words into code RAM from address 0 and commits code_size on the last word.
// Latency: write strobe and size commit one cycle after accept. Backpressure: in_ready only in LOAD, one word/cycle.
// CODE_LOADER_OVERFLOW_ERR_EN: overflow word enters ERR and raises err; otherwise overflow words are dropped.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int CODESIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSWIDTH-1:0] in_ins,
    input  logic                in_last,
    output logic                wr_en,
    output logic [PCWIDTH-1:0]  wr_addr,
    output logic [INSWIDTH-1:0] wr_data,
    output logic [3:0]          code_size,
    output logic                load_done
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
    ,
    output logic                err
`endif
);

    localparam logic [3:0] CODESIZE_W = 4'(CODESIZE);

    ldr_state_t state;
    logic [3:0] cnt;

    // Handshake and status are pure decodes of the state register.
    assign in_ready  = (state == LDR_LOAD);
    assign load_done = (state == LDR_DONE);
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
    assign err       = (state == LDR_ERR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LDR_IDLE;
            cnt       <= 4'd0;
            code_size <= 4'd0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
                LDR_IDLE, LDR_DONE, LDR_ERR: begin
`else
                LDR_IDLE, LDR_DONE: begin
`endif
                    if (start) begin
                        cnt       <= 4'd0;
                        code_size <= 4'd0;
                        state     <= LDR_LOAD;
                    end
                end
                LDR_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (cnt < CODESIZE_W) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cnt[PCWIDTH-1:0];
                            wr_data <= in_ins;
                            cnt     <= cnt + 4'd1;
                            // Size lands in the same cycle as the final write.
                            if (in_last) begin
                                code_size <= cnt + 4'd1;
                                state     <= LDR_DONE;
                            end
                        end else begin
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
                            code_size <= 4'd0;
                            state     <= LDR_ERR;
`else
                            if (in_last) begin
                                code_size <= CODESIZE_W;
                                state     <= LDR_DONE;
                            end
`endif
                        end
                    end
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Randomized scoreboard bench for code_loader: driver predicts writes/commits, monitor pops and compares.
module tb_code_loader;
    import code_loader_pkg::*;

    localparam int CODESIZE = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [INSWIDTH-1:0] in_ins;
    logic                in_last;
    logic                wr_en;
    logic [PCWIDTH-1:0]  wr_addr;
    logic [INSWIDTH-1:0] wr_data;
    logic [3:0]          code_size;
    logic                load_done;
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
    logic                err;
`endif

    code_loader #(.CODESIZE(CODESIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ins    (in_ins),
        .in_last   (in_last),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .code_size (code_size),
        .load_done (load_done)
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int size; int with_wr;} cm_t;

    wr_t exp_wr[$];
    cm_t exp_cm[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    bit prev_done = 1'b0;

    // Reference model: is a load open, and how many words have been taken so far.
    bit m_loading = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        if (!m_loading) begin
            m_loading = 1'b1;
            m_cnt = 0;
        end
        idle();
        start = 1'b0;
    endtask

    task automatic drive_word(input logic [INSWIDTH-1:0] d, input bit last, input bit with_start);
        chk("in_ready_before_word", in_ready, m_loading);
        in_valid = 1'b1;
        in_ins   = d;
        in_last  = last;
        start    = with_start;
        if (m_loading) begin
            if (m_cnt < CODESIZE) begin
                exp_wr.push_back('{addr: m_cnt, data: int'(d)});
                m_cnt++;
                if (last) begin
                    exp_cm.push_back('{size: m_cnt, with_wr: 1});
                    m_loading = 1'b0;
                end
            end else begin
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
                m_loading = 1'b0;
`else
                if (last) begin
                    exp_cm.push_back('{size: CODESIZE, with_wr: 0});
                    m_loading = 1'b0;
                end
`endif
            end
        end
        idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_words(input int n, input int last_idx, input bit gaps, input bit rs);
        for (int i = 0; i < n; i++) begin
            drive_word(16'($urandom_range(0, 16'hffff)), (i == last_idx),
                       rs && ($urandom_range(0, 3) == 0));
            if (gaps && i != n - 1) idle();
        end
    endtask

    task automatic do_load(input int n, input int last_idx, input bit gaps, input bit rs);
        pulse_start();
        do_words(n, last_idx, gaps, rs);
    endtask

    // Monitor: every write and every size commit must match the next prediction.
    always @(negedge clk) begin
        wr_t w;
        cm_t c;
        if (mon_en) begin
            if (wr_en === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(wr_addr), w.addr);
                    chk("wr_data", 32'(wr_data), w.data);
                    if (load_done !== 1'b1) chk("code_size_during_load", 32'(code_size), 0);
                end
            end
            if (load_done === 1'b1 && !prev_done) begin
                if (exp_cm.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_commit: got code_size %0d, expected no commit", code_size);
                end else begin
                    c = exp_cm.pop_front();
                    chk("commit_size", 32'(code_size), c.size);
                    chk("commit_with_write", 32'(wr_en), c.with_wr);
                end
            end
        end
        prev_done = (load_done === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_ins = '0; in_last = 1'b0;
        repeat (3) idle();
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_code_size", 32'(code_size), 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_in_ready", in_ready, 0);
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
        chk("rst_err", err, 0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;
        idle();

        // Basic three-word program.
        pulse_start();
        @(negedge clk);
        chk("ready_after_start", in_ready, 1);
        drive_word(16'h0011, 1'b0, 1'b0);
        drive_word(16'h0022, 1'b0, 1'b0);
        drive_word(16'h0033, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_code_size", 32'(code_size), 3);
        chk("t1_load_done", load_done, 1);
        chk("t1_in_ready", in_ready, 0);

        // Restart from DONE clears the committed size immediately.
        pulse_start();
        @(negedge clk);
        chk("restart_code_size", 32'(code_size), 0);
        chk("restart_in_ready", in_ready, 1);
        chk("restart_load_done", load_done, 0);
        do_words(4, 3, 1'b1, 1'b0);
        @(negedge clk);
        chk("gaps_code_size", 32'(code_size), 4);

        // Full-depth program.
        do_load(CODESIZE, CODESIZE - 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_code_size", 32'(code_size), CODESIZE);
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
        chk("full_err", err, 0);
`endif

        // One word too many.
        do_load(CODESIZE + 1, CODESIZE, 1'b0, 1'b0);
        @(negedge clk);
`ifdef CODE_LOADER_OVERFLOW_ERR_EN
        chk("ovf_err", err, 1);
        chk("ovf_code_size", 32'(code_size), 0);
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_load_done", load_done, 0);
        do_load(2, 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("after_err_code_size", 32'(code_size), 2);
        chk("after_err_err", err, 0);
`else
        chk("ovf_code_size", 32'(code_size), CODESIZE);
        chk("ovf_load_done", load_done, 1);
        do_load(CODESIZE + 3, CODESIZE + 2, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovf3_code_size", 32'(code_size), CODESIZE);
`endif

        // Reset in the middle of a load, then reload from address 0.
        do_load(2, -1, 1'b0, 1'b0);
        rst = 1'b1;
        m_loading = 1'b0;
        m_cnt = 0;
        idle();
        @(negedge clk);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", 32'(wr_addr), 0);
        chk("midrst_wr_data", 32'(wr_data), 0);
        chk("midrst_code_size", 32'(code_size), 0);
        chk("midrst_load_done", load_done, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        idle();
        do_load(4, 3, 1'b0, 1'b0);
        @(negedge clk);
        chk("reload_code_size", 32'(code_size), 4);

        // Random programs with random gaps, stray starts and stray words outside LOAD.
        for (int k = 0; k < 16; k++) begin
            int n;
            n = $urandom_range(1, CODESIZE);
            do_load(n, n - 1, 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
            chk("rand_code_size", 32'(code_size), n);
            if ($urandom_range(0, 1) == 1) begin
                drive_word(16'($urandom_range(0, 16'hffff)), 1'b1, 1'b0);
                @(negedge clk);
                chk("stray_code_size", 32'(code_size), n);
            end
        end

        repeat (3) idle();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("commit_queue_empty", exp_cm.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
